// File: rtl/eth_frame_tx_if.sv
// Ethernet frame TX bus bundle: header, payload stream, frame stream.
// slave = eth_frame_tx view; master = the surrounding logic view.
interface eth_frame_tx_if;
  logic        s_eth_hdr_valid;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac;
  logic [47:0] s_eth_src_mac;
  logic [15:0] s_eth_type;

  logic [7:0]  s_eth_payload_axis_tdata;
  logic        s_eth_payload_axis_tvalid;
  logic        s_eth_payload_axis_tready;
  logic        s_eth_payload_axis_tlast;
  logic        s_eth_payload_axis_tuser;

  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;

  modport slave (
    input  s_eth_hdr_valid,
    output s_eth_hdr_ready,
    input  s_eth_dest_mac,
    input  s_eth_src_mac,
    input  s_eth_type,
    input  s_eth_payload_axis_tdata,
    input  s_eth_payload_axis_tvalid,
    output s_eth_payload_axis_tready,
    input  s_eth_payload_axis_tlast,
    input  s_eth_payload_axis_tuser,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast,
    output m_axis_tuser
  );

  modport master (
    output s_eth_hdr_valid,
    input  s_eth_hdr_ready,
    output s_eth_dest_mac,
    output s_eth_src_mac,
    output s_eth_type,
    output s_eth_payload_axis_tdata,
    output s_eth_payload_axis_tvalid,
    input  s_eth_payload_axis_tready,
    output s_eth_payload_axis_tlast,
    output s_eth_payload_axis_tuser,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast,
    input  m_axis_tuser
  );
endinterface

// File: rtl/eth_frame_tx.sv
// Ethernet frame serializer: 14-byte header, payload pass-through,
// optional zero padding up to a minimum frame length.
module eth_frame_tx #(
  parameter bit ENABLE_PADDING   = 1'b1,
  parameter int MIN_FRAME_LENGTH = 60
) (
  input  logic           clk,
  input  logic           rst,
  eth_frame_tx_if.slave  bus,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PAD
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [111:0]  hdr_q;
  logic [15:0]   cnt_q;
  logic          tuser_q;
  logic          armed_q;
  logic          hdr_fire;
  logic          out_fire;
  logic          pad_needed;
  logic          pad_last;
  logic [16:0]   cnt_inc;

  assign hdr_fire = (state_q == IDLE) && armed_q
                  && bus.s_eth_hdr_valid;
  assign out_fire = bus.m_axis_tvalid && bus.m_axis_tready;
  assign cnt_inc  = {1'b0, cnt_q} + 17'd1;

  assign pad_needed = ENABLE_PADDING &&
    ({15'd0, cnt_inc} < 32'(MIN_FRAME_LENGTH));
  assign pad_last =
    ({16'd0, cnt_q} == 32'(MIN_FRAME_LENGTH - 1));

  assign busy = (state_q != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and output muxing per state
  always_comb begin
    state_d                       = state_q;
    bus.s_eth_hdr_ready           = 1'b0;
    bus.s_eth_payload_axis_tready = 1'b0;
    bus.m_axis_tdata              = 8'h00;
    bus.m_axis_tvalid             = 1'b0;
    bus.m_axis_tlast              = 1'b0;
    bus.m_axis_tuser              = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.s_eth_hdr_ready = armed_q;
        if (hdr_fire) state_d = HEADER;
      end
      HEADER: begin
        bus.m_axis_tdata  = hdr_q[111:104];
        bus.m_axis_tvalid = 1'b1;
        if (bus.m_axis_tready && cnt_q == 16'd13)
          state_d = PAYLOAD;
      end
      PAYLOAD: begin
        bus.m_axis_tdata  = bus.s_eth_payload_axis_tdata;
        bus.m_axis_tvalid = bus.s_eth_payload_axis_tvalid;
        bus.m_axis_tlast  = bus.s_eth_payload_axis_tlast;
        bus.m_axis_tuser  = bus.s_eth_payload_axis_tuser;
        bus.s_eth_payload_axis_tready = bus.m_axis_tready;
        if (bus.s_eth_payload_axis_tlast && pad_needed) begin
          bus.m_axis_tlast = 1'b0;
          bus.m_axis_tuser = 1'b0;
        end
        if (bus.s_eth_payload_axis_tvalid &&
            bus.m_axis_tready &&
            bus.s_eth_payload_axis_tlast)
          state_d = pad_needed ? PAD : IDLE;
      end
      PAD: begin
        bus.m_axis_tvalid = 1'b1;
        if (pad_last) begin
          bus.m_axis_tlast = 1'b1;
          bus.m_axis_tuser = tuser_q;
          if (bus.m_axis_tready) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Header shift register, byte counter and latched tuser
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_q   <= '0;
      cnt_q   <= '0;
      tuser_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (hdr_fire) begin
        hdr_q <= {bus.s_eth_dest_mac,
                  bus.s_eth_src_mac,
                  bus.s_eth_type};
        cnt_q <= '0;
      end else if (out_fire) begin
        if (cnt_q != 16'hFFFF) cnt_q <= cnt_inc[15:0];
        if (state_q == HEADER)
          hdr_q <= {hdr_q[103:0], 8'h00};
        if (state_q == PAYLOAD &&
            bus.s_eth_payload_axis_tlast && pad_needed)
          tuser_q <= bus.s_eth_payload_axis_tuser;
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed bench for eth_frame_tx with a byte scoreboard.
// Two instances: padding enabled (a) and disabled (b).
module tb_eth_frame_tx;

  logic clk;
  logic rst;

  logic        sel;
  logic        hv;
  logic [47:0] dmac;
  logic [47:0] smac;
  logic [15:0] etyp;
  logic [7:0]  pd;
  logic        pv;
  logic        pl;
  logic        pu;
  logic        mr;
  logic        busy_a;
  logic        busy_b;

  eth_frame_tx_if bus_a ();
  eth_frame_tx_if bus_b ();

  assign bus_a.s_eth_hdr_valid = hv && !sel;
  assign bus_a.s_eth_dest_mac = dmac;
  assign bus_a.s_eth_src_mac = smac;
  assign bus_a.s_eth_type = etyp;
  assign bus_a.s_eth_payload_axis_tdata = pd;
  assign bus_a.s_eth_payload_axis_tvalid = pv && !sel;
  assign bus_a.s_eth_payload_axis_tlast = pl;
  assign bus_a.s_eth_payload_axis_tuser = pu;
  assign bus_a.m_axis_tready = mr;

  assign bus_b.s_eth_hdr_valid = hv && sel;
  assign bus_b.s_eth_dest_mac = dmac;
  assign bus_b.s_eth_src_mac = smac;
  assign bus_b.s_eth_type = etyp;
  assign bus_b.s_eth_payload_axis_tdata = pd;
  assign bus_b.s_eth_payload_axis_tvalid = pv && sel;
  assign bus_b.s_eth_payload_axis_tlast = pl;
  assign bus_b.s_eth_payload_axis_tuser = pu;
  assign bus_b.m_axis_tready = mr;

  eth_frame_tx #(
    .ENABLE_PADDING   (1'b1),
    .MIN_FRAME_LENGTH (60)
  ) dut_a (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_a),
    .busy (busy_a)
  );

  eth_frame_tx #(
    .ENABLE_PADDING   (1'b0),
    .MIN_FRAME_LENGTH (60)
  ) dut_b (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_b),
    .busy (busy_b)
  );

  logic [7:0] o_td;
  logic       o_tv;
  logic       o_tl;
  logic       o_tu;
  logic       o_hr;
  logic       o_ptr;
  logic       o_busy;

  assign o_td = sel ? bus_b.m_axis_tdata : bus_a.m_axis_tdata;
  assign o_tv = sel ? bus_b.m_axis_tvalid : bus_a.m_axis_tvalid;
  assign o_tl = sel ? bus_b.m_axis_tlast : bus_a.m_axis_tlast;
  assign o_tu = sel ? bus_b.m_axis_tuser : bus_a.m_axis_tuser;
  assign o_hr = sel ? bus_b.s_eth_hdr_ready
                    : bus_a.s_eth_hdr_ready;
  assign o_ptr = sel ? bus_b.s_eth_payload_axis_tready
                     : bus_a.s_eth_payload_axis_tready;
  assign o_busy = sel ? busy_b : busy_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks;
  int         errors;
  logic [9:0] sb[$];
  logic [7:0] pay[$];
  int         out_cnt;
  bit         toggle;
  bit         stalled;
  logic [7:0] prev_td;
  bit         hs_hdr;
  bit         hs_pl;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One cycle: sample just before the edge, then advance.
  task automatic step();
    logic [9:0] e;
    @(negedge clk);
    if (stalled) begin
      chk("stall_valid", {31'd0, o_tv}, 32'd1);
      chk("stall_data", {24'd0, o_td}, {24'd0, prev_td});
    end
    stalled = o_tv && !mr;
    prev_td = o_td;
    hs_hdr = hv && o_hr;
    hs_pl = pv && o_ptr;
    if (o_tv && mr) begin
      if (sb.size() == 0) begin
        chk("extra_byte", sb.size(), 32'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("byte%0d", out_cnt),
            {22'd0, o_tl, o_tu, o_td}, {22'd0, e});
      end
      out_cnt++;
    end
    @(posedge clk);
    #1;
    if (toggle) mr = ~mr;
  endtask

  task automatic send_frame(input bit s,
                            input logic [15:0] t,
                            input bit lastuser,
                            input bit tog,
                            input int abort_at);
    int n;
    int total;
    int k;
    logic [111:0] hdr;
    logic [7:0] b;
    bit lst;
    n = pay.size();
    sel = s;
    toggle = tog;
    mr = 1'b1;
    stalled = 1'b0;
    dmac = 48'h02_00_00_00_00_01;
    smac = 48'h02_00_00_00_00_02;
    etyp = t;
    hdr = {dmac, smac, etyp};
    total = 14 + n;
    if (!s && total < 60) total = 60;
    for (int i = 0; i < total; i++) begin
      if (i < 14) b = hdr[111 - 8 * i -: 8];
      else if (i < 14 + n) b = pay[i - 14];
      else b = 8'h00;
      lst = (i == total - 1);
      sb.push_back({lst, lst && lastuser, b});
    end
    out_cnt = 0;
    hv = 1'b1;
    hs_hdr = 1'b0;
    k = 0;
    while (!hs_hdr && k < 20) begin
      step();
      k++;
    end
    chk("hdr_handshake", {31'd0, hs_hdr}, 32'd1);
    hv = 1'b0;
    chk("hdr_latency", {31'd0, o_tv}, 32'd1);
    for (int i = 0; i < n; i++) begin
      pv = 1'b1;
      pd = pay[i];
      pl = (i == n - 1);
      pu = (i == n - 1) && lastuser;
      hs_pl = 1'b0;
      k = 0;
      while (!hs_pl && k < 100) begin
        if (abort_at >= 0 && out_cnt == abort_at) begin
          chk("pre_rst_valid", {31'd0, o_tv}, 32'd1);
          rst = 1'b0;
          #1;
          chk("rst_valid", {31'd0, o_tv}, 32'd0);
          chk("rst_busy", {31'd0, o_busy}, 32'd0);
          chk("rst_hdr_ready", {31'd0, o_hr}, 32'd0);
          pv = 1'b0;
          pl = 1'b0;
          pu = 1'b0;
          sb.delete();
          stalled = 1'b0;
          @(posedge clk);
          #1;
          rst = 1'b1;
          @(posedge clk);
          #1;
          chk("post_rst_ready", {31'd0, o_hr}, 32'd1);
          chk("post_rst_busy", {31'd0, o_busy}, 32'd0);
          return;
        end
        step();
        k++;
      end
      chk("pl_handshake", {31'd0, hs_pl}, 32'd1);
    end
    pv = 1'b0;
    pl = 1'b0;
    pu = 1'b0;
    k = 0;
    while (sb.size() > 0 && k < 400) begin
      step();
      k++;
    end
    chk("drain", sb.size(), 32'd0);
    chk("length", out_cnt, total);
    toggle = 1'b0;
    mr = 1'b1;
    chk("idle_busy", {31'd0, o_busy}, 32'd0);
    chk("idle_ready", {31'd0, o_hr}, 32'd1);
  endtask

  task automatic fill(input int n, input int base);
    pay.delete();
    for (int i = 0; i < n; i++)
      pay.push_back(8'(base + i));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    out_cnt = 0;
    toggle = 1'b0;
    stalled = 1'b0;
    prev_td = 8'h00;
    hs_hdr = 1'b0;
    hs_pl = 1'b0;
    rst = 1'b0;
    sel = 1'b0;
    hv = 1'b0;
    dmac = '0;
    smac = '0;
    etyp = '0;
    pd = '0;
    pv = 1'b0;
    pl = 1'b0;
    pu = 1'b0;
    mr = 1'b1;

    #12;
    chk("rst_tvalid", {31'd0, o_tv}, 32'd0);
    chk("rst_tdata", {24'd0, o_td}, 32'd0);
    chk("rst_tlast", {31'd0, o_tl}, 32'd0);
    chk("rst_tuser", {31'd0, o_tu}, 32'd0);
    chk("rst_ready", {31'd0, o_hr}, 32'd0);
    chk("rst_ptready", {31'd0, o_ptr}, 32'd0);
    chk("rst_busy0", {31'd0, o_busy}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("first_ready", {31'd0, o_hr}, 32'd1);

    fill(46, 0);
    send_frame(1'b0, 16'h0800, 1'b0, 1'b0, -1);
    step();

    fill(1, 8'hAB);
    send_frame(1'b0, 16'h0806, 1'b0, 1'b0, -1);

    fill(10, 8'h10);
    send_frame(1'b0, 16'h0800, 1'b1, 1'b0, -1);

    fill(46, 0);
    send_frame(1'b0, 16'h0800, 1'b0, 1'b1, -1);

    fill(45, 8'h80);
    send_frame(1'b0, 16'h86DD, 1'b1, 1'b0, -1);

    fill(46, 0);
    send_frame(1'b0, 16'h0800, 1'b0, 1'b0, 20);
    fill(46, 0);
    send_frame(1'b0, 16'h0800, 1'b0, 1'b0, -1);

    fill(1, 8'h55);
    send_frame(1'b1, 16'h0800, 1'b0, 1'b0, -1);
    fill(70, 8'h20);
    send_frame(1'b1, 16'h0800, 1'b1, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
